// File: rtl/riscv_pkg.sv
// Shared decode definitions: opcodes, immediate-format select, decode stage
// state and the stored pipeline entry.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        immsrc_t     immsrc;
        logic [31:0] immext;
        logic        has_imm;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/imm_decode_stage_extend.sv
// Immediate extender: assembles and sign-extends the immediate field of an
// instruction according to the selected format.
module extend
    import riscv_pkg::*;
(
    input  logic [31:7] instr_i,
    input  immsrc_t     immsrc_i,
    output logic [31:0] immext_o
);

    always_comb begin
        immext_o = '0;
        case (immsrc_i)
            IMM_I: immext_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: immext_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: immext_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0};
            IMM_J: immext_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                               instr_i[30:21], 1'b0};
            IMM_U: immext_o = {instr_i[31:12], 12'b0};
            default: immext_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with a main + skid entry, valid/ready on
// both sides and a priority flush.
module imm_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      immsrc_o,
    output logic [31:0]     immext_o,
    output logic            has_imm_o,
    output logic            illegal_o,
    output logic [31:0]     accept_cnt_o
);

    immsrc_t      dec_immsrc;
    logic         dec_has_imm;
    logic         dec_illegal;
    logic [31:0]  ext_imm;
    entry_t       in_entry;

    stage_state_t state_q, state_d;
    logic         ready_q, ready_d;
    entry_t       main_q, main_d;
    entry_t       skid_q, skid_d;
    logic [31:0]  accept_cnt_q, accept_cnt_d;

    logic         accept;
    logic         xfer;

    always_comb begin
        dec_immsrc  = IMM_I;
        dec_has_imm = 1'b1;
        dec_illegal = 1'b0;
        case (instr_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR: dec_immsrc = IMM_I;
            OP_STORE:                 dec_immsrc = IMM_S;
            OP_BRANCH:                dec_immsrc = IMM_B;
            OP_JAL:                   dec_immsrc = IMM_J;
            OP_LUI, OP_AUIPC:         dec_immsrc = IMM_U;
            OP_R:                     dec_has_imm = 1'b0;
            default: begin
                dec_has_imm = 1'b0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    extend u_extend (
        .instr_i  (instr_i[31:7]),
        .immsrc_i (dec_immsrc),
        .immext_o (ext_imm)
    );

    // R-type and illegal instructions carry no immediate, so force it to zero.
    always_comb begin
        in_entry         = '0;
        in_entry.instr   = instr_i;
        in_entry.pc      = pc_i;
        in_entry.immsrc  = dec_immsrc;
        in_entry.immext  = dec_has_imm ? ext_imm : 32'd0;
        in_entry.has_imm = dec_has_imm;
        in_entry.illegal = dec_illegal;
    end

    assign valid_o = (state_q != ST_EMPTY);
    assign accept  = valid_i && ready_q && !flush_i;
    assign xfer    = valid_o && ready_i;

    always_comb begin
        state_d      = state_q;
        main_d       = main_q;
        skid_d       = skid_q;
        accept_cnt_d = accept_cnt_q + {31'd0, accept};
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && xfer) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_FULL;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Main always holds the older entry; skid advances on drain.
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_EMPTY;
            ready_q      <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
            accept_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign ready_o      = ready_q;
    assign instr_o      = main_q.instr;
    assign pc_o         = main_q.pc[XLEN-1:0];
    assign immsrc_o     = main_q.immsrc;
    assign immext_o     = main_q.immext;
    assign has_imm_o    = main_q.has_imm;
    assign illegal_o    = main_q.illegal;
    assign accept_cnt_o = accept_cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: accepted instructions are predicted
// by a reference decoder and checked in order as they leave the stage.
module tb_imm_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [2:0]  immsrc_o;
    logic [31:0] immext_o;
    logic        has_imm_o;
    logic        illegal_o;
    logic [31:0] accept_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  immsrc;
        logic [31:0] immext;
        logic        has_imm;
        logic        illegal;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .immsrc_o     (immsrc_o),
        .immext_o     (immext_o),
        .has_imm_o    (has_imm_o),
        .illegal_o    (illegal_o),
        .accept_cnt_o (accept_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e.instr   = i;
        e.pc      = pc;
        e.immsrc  = 3'b000;
        e.immext  = 32'd0;
        e.has_imm = 1'b1;
        e.illegal = 1'b0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                e.immsrc = 3'b000;
                e.immext = {{20{i[31]}}, i[31:20]};
            end
            7'b0100011: begin
                e.immsrc = 3'b001;
                e.immext = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'b1100011: begin
                e.immsrc = 3'b010;
                e.immext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b1101111: begin
                e.immsrc = 3'b011;
                e.immext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.immsrc = 3'b100;
                e.immext = {i[31:12], 12'b0};
            end
            7'b0110011: e.has_imm = 1'b0;
            default: begin
                e.has_imm = 1'b0;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Scoreboard: pop on transfer, push on accept; flush/reset empty it.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_n_i || flush_i) begin
            sb.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", {31'd0, valid_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_instr",   instr_o,             e.instr);
                    check("sb_pc",      pc_o,                e.pc);
                    check("sb_immsrc",  {29'd0, immsrc_o},   {29'd0, e.immsrc});
                    check("sb_immext",  immext_o,            e.immext);
                    check("sb_has_imm", {31'd0, has_imm_o},  {31'd0, e.has_imm});
                    check("sb_illegal", {31'd0, illegal_o},  {31'd0, e.illegal});
                end
            end
            if (valid_i && ready_o) sb.push_back(ref_decode(instr_i, pc_i));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    logic [31:0] fmt_instr [7] = '{32'hFFF00093, 32'h00112423, 32'hFE000EE3,
                                   32'h0080006F, 32'h123452B7, 32'h002081B3,
                                   32'h0000007F};
    logic [2:0]  fmt_src   [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    logic [31:0] fmt_imm   [7] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h8,
                                   32'h12345000, 32'h0, 32'h0};
    logic        fmt_has   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        fmt_ill   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [6:0]  ops       [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                    7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                                    7'b0110011, 7'b1111111};

    initial begin
        logic [31:0] r;
        int          guard;

        rst_n_i = 1'b0;
        valid_i = 1'b1;
        instr_i = 32'h00500093;
        pc_i    = 32'h100;
        flush_i = 1'b0;
        ready_i = 1'b0;

        // Reset held with valid_i high.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_ready_o", {31'd0, ready_o}, 32'd1);
        check("rst_cnt",     accept_cnt_o,     32'd0);
        check("rst_instr_o", instr_o,          32'd0);
        step();
        rst_n_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;

        // One instruction per format, checked against fixed expectations.
        for (int k = 0; k < 7; k++) begin
            valid_i = 1'b1;
            instr_i = fmt_instr[k];
            pc_i    = 32'h1000 + 32'(k * 4);
            step();
            valid_i = 1'b0;
            @(negedge clk_i);
            check("fmt_valid",   {31'd0, valid_o},   32'd1);
            check("fmt_immsrc",  {29'd0, immsrc_o},  {29'd0, fmt_src[k]});
            check("fmt_immext",  immext_o,           fmt_imm[k]);
            check("fmt_has_imm", {31'd0, has_imm_o}, {31'd0, fmt_has[k]});
            check("fmt_illegal", {31'd0, illegal_o}, {31'd0, fmt_ill[k]});
            step();
        end
        @(negedge clk_i);
        check("fmt_cnt",   accept_cnt_o, 32'd7);
        check("fmt_drain", 32'(sb.size()), 32'd0);

        // Back-pressure: A then B with downstream stalled.
        step();
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr_i = 32'h00A00113;
        pc_i    = 32'h2000;
        step();
        instr_i = 32'h00B00193;
        pc_i    = 32'h2004;
        @(negedge clk_i);
        check("bp_ready_busy", {31'd0, ready_o}, 32'd1);
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_ready_full", {31'd0, ready_o}, 32'd0);
        step();
        step();
        @(negedge clk_i);
        check("bp_hold_instr", instr_o,          32'h00A00113);
        check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
        check("bp_hold_ready", {31'd0, ready_o}, 32'd0);
        step();
        ready_i = 1'b1;
        repeat (3) step();
        @(negedge clk_i);
        check("bp_drain",     32'(sb.size()),    32'd0);
        check("bp_empty",     {31'd0, valid_o},  32'd0);
        check("bp_ready_end", {31'd0, ready_o},  32'd1);
        check("bp_cnt",       accept_cnt_o,      32'd9);

        // Flush while FULL with a same-cycle input.
        step();
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr_i = 32'h00C00213;
        step();
        instr_i = 32'h00D00293;
        step();
        instr_i = 32'h00E00313;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("fl_pre_ready", {31'd0, ready_o}, 32'd0);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_valid_o", {31'd0, valid_o}, 32'd0);
        check("fl_ready_o", {31'd0, ready_o}, 32'd1);
        check("fl_cnt",     accept_cnt_o,     32'd11);

        // Counter wrap.
        step();
        ready_i = 1'b1;
        force dut.accept_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.accept_cnt_q;
        @(negedge clk_i);
        check("wrap_pre", accept_cnt_o, 32'hFFFF_FFFF);
        step();
        valid_i = 1'b1;
        instr_i = 32'h00100393;
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("wrap_cnt", accept_cnt_o, 32'd0);

        // Random traffic with random stalls.
        for (int n = 0; n < 80; n++) begin
            step();
            r       = $urandom();
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            instr_i = {r[31:7], ops[$urandom_range(0, 9)]};
            pc_i    = $urandom();
        end
        step();
        valid_i = 1'b0;
        ready_i = 1'b1;
        guard   = 0;
        while (sb.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        @(negedge clk_i);
        check("rnd_drain", 32'(sb.size()),   32'd0);
        check("rnd_empty", {31'd0, valid_o}, 32'd0);

        // Reset asserted while FULL.
        step();
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr_i = 32'h00200413;
        step();
        instr_i = 32'h00300493;
        step();
        valid_i = 1'b0;
        rst_n_i = 1'b0;
        step();
        @(negedge clk_i);
        check("rf_valid_o", {31'd0, valid_o}, 32'd0);
        check("rf_ready_o", {31'd0, ready_o}, 32'd1);
        check("rf_cnt",     accept_cnt_o,     32'd0);
        step();
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        repeat (4) step();
        @(negedge clk_i);
        check("rf_no_stale", {31'd0, valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
